controlador_serial: RTL
=======================

# controlador_serial

Sequencer for the 4-bit universal shift register and its `salidaSerial` output selector. It accepts a parallel word through a valid/ready handshake, drives `modo` and `dir` to load the register and shift it out bit by bit, and re-times the selected serial bit into a qualified output stream. Ends each word with a one-cycle completion pulse and can stall the shift without losing bits.

## Interface
- `N`, 4: word width; must equal the shift-register width; N ≥ 2.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ini_valido` in 1: request to transmit `dato_in`.
- `ini_listo` out 1: controller can accept a word.
- `dato_in` in N: parallel word.
- `dir_in` in 1: direction. 0 sends LSB first via `s_der`; 1 sends MSB first via `s_izq`.
- `pausa` in 1: stall the shift while high.
- `s_out` in 1: serial bit from `salidaSerial`.
- `modo` out 2: register mode. 00 shift, 01 rotate (unused), 10 parallel load, 11 hold.
- `dir` out 1: shift direction to register and `salidaSerial`.
- `dato_carga` out N: parallel data to register.
- `tx_bit` out 1: serial data bit.
- `tx_valido` out 1: `tx_bit` is valid this cycle.
- `fin` out 1: one-cycle pulse after the last bit.

## Operation
- States:
  - IDLE: `ini_listo`=1, `modo`=11.
  - CARGA: `modo`=10, `dato_carga`=captured word.
  - DESPLAZA: `modo`=00, unless paused.
  - PARIDAD: only when the parity option is compiled in.
  - FIN: `modo`=11, `fin`=1.
- Transitions:
  - IDLE→CARGA when `ini_valido`&&`ini_listo` on a clock edge. On that edge, capture `dato_in` and `dir_in`.
  - CARGA→DESPLAZA unconditionally.
  - DESPLAZA→PARIDAD/FIN once N bits have been emitted.
  - PARIDAD→FIN.
  - FIN→IDLE.
- `dir` holds the captured direction from CARGA through FIN. In IDLE, `dir` keeps its last value.
- DESPLAZA bit emission:
  - `tx_bit`=`s_out` and `tx_valido`=1 each unpaused cycle.
  - The bit counter (width clog2(N)+1) increments on each such cycle.
  - Exit after count reaches N−1 and that bit is emitted.
- `pausa` behaviour:
  - `pausa`=1 in DESPLAZA: `modo`=11, `tx_valido`=0, counter frozen, state held.
  - `pausa` is ignored in all other states.
- `ini_valido` outside IDLE is ignored and is not queued. `dato_in` and `dir_in` changes after capture have no effect.
- Reset values:
  - State IDLE, counter 0.
  - `modo`=11, `dir`=0, `dato_carga`=0.
  - `tx_bit`=0, `tx_valido`=0, `fin`=0, `ini_listo`=1.
- Reset asserted mid-word aborts immediately to the reset values. No `fin` is produced.

## Timing
- Outputs are registered, except `ini_listo` and `tx_bit`, which are decoded combinationally from state and `s_out`.
- Handshake on edge k gives:
  - CARGA during cycle k+1.
  - First valid bit in cycle k+2.
  - Last bit in cycle k+N+1, with no pauses.
  - `fin` in cycle k+N+2, or k+N+3 with parity.
  - `ini_listo` high again in cycle k+N+3 (no parity) or k+N+4 (parity).
- Each `pausa` cycle in DESPLAZA delays all later events by one cycle.
- Back-to-back words: minimum N+3 cycles per word between handshakes without parity, N+4 with parity.

## Configuration
- `CONTROLADOR_SERIAL_PARIDAD_EN` defined:
  - The even parity of the captured word is computed at capture.
  - It is sent as one extra PARIDAD cycle: `tx_bit`=parity, `tx_valido`=1, `modo`=11.
  - `pausa` is ignored in this cycle.
- Undefined: PARIDAD state and parity logic are absent; DESPLAZA goes directly to FIN.

## Structure
- The shared package `controlador_serial_pkg` holds:
  - State encodings (IDLE=0, CARGA=1, DESPLAZA=2, PARIDAD=3, FIN=4).
  - Mode constants MODO_DESP=2'b00, MODO_ROT=2'b01, MODO_CARGA=2'b10, MODO_RET=2'b11.
- One sub-module, `contador_bits`: clear, enable, and terminal-count flag at N−1. The FSM and output registers stay in the top.

## Test plan
- Reset: assert `reset_n`=0 mid-run → `modo`=11, `tx_valido`=0, `fin`=0, `ini_listo`=1 asynchronously.
- `dato_in`=4'b1011, `dir_in`=0, no pausa → `modo` 10 for one cycle, then `tx_bit` 1,1,0,1 with `tx_valido`=1; `fin` at k+6 (k+7 with parity, parity bit 1).
- `dato_in`=4'b1011, `dir_in`=1 → `dir`=1 held, `tx_bit` 1,0,1,1.
- `pausa` high for 2 cycles after the second bit → `modo`=11 and `tx_valido`=0 during the pause, no bit lost or repeated, `fin` 2 cycles later.
- `ini_valido` held high continuously with words 4'hA then 4'h5 → the second handshake occurs exactly N+3 (parity: N+4) cycles after the first; a `dato_in` change mid-word does not alter the stream.
- `reset_n` pulsed low after the third bit → no `fin`; the next handshake restarts from the first bit.

Source files
------------

// File: rtl/controlador_serial_pkg.sv
// controlador_serial_pkg: FSM state encodings and shift-register mode constants
package controlador_serial_pkg;
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CARGA    = 3'd1,
      DESPLAZA = 3'd2,
      PARIDAD  = 3'd3,
      FIN      = 3'd4
   } estado_t;
   localparam logic [1:0] MODO_DESP  = 2'b00;
   localparam logic [1:0] MODO_ROT   = 2'b01;
   localparam logic [1:0] MODO_CARGA = 2'b10;
   localparam logic [1:0] MODO_RET   = 2'b11;
endpackage

// File: rtl/controlador_serial_contador_bits.sv
// contador_bits: emitted-bit counter with clear, enable and terminal flag at N-1
module contador_bits #(
   parameter int N = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic ultimo
);
   localparam int W = $clog2(N) + 1;
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
   assign ultimo = cnt == W'(N - 1);
endmodule

// File: rtl/controlador_serial.sv
// controlador_serial: valid/ready sequencer that loads the shift register and streams it out bit by bit
// CONTROLADOR_SERIAL_PARIDAD_EN appends an even-parity bit after the data bits
module controlador_serial
   import controlador_serial_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         ini_valido,
   output logic         ini_listo,
   input  logic [N-1:0] dato_in,
   input  logic         dir_in,
   input  logic         pausa,
   input  logic         s_out,
   output logic [1:0]   modo,
   output logic         dir,
   output logic [N-1:0] dato_carga,
   output logic         tx_bit,
   output logic         tx_valido,
   output logic         fin
);
   estado_t    estado, estado_d;
   logic [1:0] modo_d;
   logic       tx_valido_d, fin_d, ultimo, captura;
   assign ini_listo = estado == IDLE;
   assign captura   = ini_valido && ini_listo;
`ifdef CONTROLADOR_SERIAL_PARIDAD_EN
   logic paridad;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) paridad <= 1'b0;
      else if (captura) paridad <= ^dato_in;
   assign tx_bit = tx_valido && (estado == PARIDAD ? paridad : s_out);
`else
   assign tx_bit = tx_valido && s_out;
`endif
   // the register only shifts in cycles flagged valid, so the count follows tx_valido
   contador_bits #(.N(N)) u_contador (
      .clk    (clk),
      .reset_n(reset_n),
      .clr    (estado != DESPLAZA),
      .en     (estado == DESPLAZA && tx_valido),
      .ultimo (ultimo)
   );
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) estado <= IDLE;
      else estado <= estado_d;
   always_comb begin
      estado_d = estado;
      case (estado)
         IDLE:     estado_d = captura ? CARGA : IDLE;
         CARGA:    estado_d = DESPLAZA;
`ifdef CONTROLADOR_SERIAL_PARIDAD_EN
         DESPLAZA: estado_d = tx_valido && ultimo ? PARIDAD : DESPLAZA;
         PARIDAD:  estado_d = FIN;
`else
         DESPLAZA: estado_d = tx_valido && ultimo ? FIN : DESPLAZA;
`endif
         FIN:      estado_d = IDLE;
         default:  estado_d = IDLE;
      endcase
   end
   // registered outputs are decoded from the state being entered
   always_comb begin
      modo_d      = MODO_RET;
      tx_valido_d = 1'b0;
      fin_d       = 1'b0;
      case (estado_d)
         CARGA:    modo_d = MODO_CARGA;
         DESPLAZA: begin
            modo_d      = pausa ? MODO_RET : MODO_DESP;
            tx_valido_d = !pausa;
         end
`ifdef CONTROLADOR_SERIAL_PARIDAD_EN
         PARIDAD:  tx_valido_d = 1'b1;
`endif
         FIN:      fin_d = 1'b1;
         default:  modo_d = MODO_RET;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         modo       <= MODO_RET;
         dir        <= 1'b0;
         dato_carga <= '0;
         tx_valido  <= 1'b0;
         fin        <= 1'b0;
      end else begin
         modo      <= modo_d;
         tx_valido <= tx_valido_d;
         fin       <= fin_d;
         if (captura) begin
            dir        <= dir_in;
            dato_carga <= dato_in;
         end
      end
endmodule
